button_pulse_gen: RTL

- Upstream stage of semaphore_ctrl.
- Turns a raw, asynchronous, bouncing pedestrian push-button into a clean single-cycle `pulso` request.
- Stages: 2-flop synchronizer, debounce FSM, post-release hold-off to rate-limit requests, wrap-around count of issued pulses for debug.
- `pulso` connects directly to semaphore_ctrl.pulso on the same `clk`.

---
 rtl/button_pulse_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/button_pulse_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/button_pulse_pkg.sv
// Shared types and defaults for the push-button front end of semaphore_ctrl.
package button_pulse_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    PRESSED   = 3'd2,
    DEB_REL   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int HOLDOFF_CYCLES_DEF  = 8;

  // Larger of two integers, used to size the shared debounce/hold-off counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous level inputs; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_pulse_gen.sv
// Debounced, rate-limited single-cycle request pulse from a raw push-button.
module button_pulse_gen
  import button_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             botao,
  output logic             pulso,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_count
);

  // One counter serves both the debounce windows and the hold-off window.
  localparam int CW = $clog2(max_int(DEBOUNCE_CYCLES, HOLDOFF_CYCLES) + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);

  logic          botao_s;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          fire;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (botao),
    .q     (botao_s)
  );

  // Next-state decode; fire marks the single transition that issues a request.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (botao_s) begin
          state_nxt = DEB_PRESS;
          cnt_nxt   = '0;
        end
      end
      DEB_PRESS: begin
        if (!botao_s) begin
          state_nxt = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_nxt = PRESSED;
          fire      = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!botao_s) begin
          state_nxt = DEB_REL;
          cnt_nxt   = '0;
        end
      end
      DEB_REL: begin
        // A bounce back to pressed resumes the same press without a new pulse.
        if (botao_s) begin
          state_nxt = PRESSED;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HOLDOFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered outputs: pulso lasts one cycle since fire only occurs on leaving DEB_PRESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulso       <= 1'b0;
      busy        <= 1'b0;
      pulse_count <= '0;
    end else begin
      pulso <= fire;
      busy  <= (state_nxt != IDLE);
      if (fire) begin
        pulse_count <= pulse_count + CNT_W'(1);
      end
    end
  end

endmodule
